freq_meter: RTL

Input-frequency meter: the measuring counterpart to the team's clock divider. It takes an asynchronous square wave `sigin`, synchronizes it to `clk`, and reports two results: the edge count per gate window, which is Hz when the gate is 1 s, and the period of the most recent cycle in `clk` cycles. It sits beside the divider outputs and external inputs, and feeds display/debug logic with registered results plus one-cycle valid strobes.

---
 rtl/freq_meter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// Input-frequency meter: counts synchronized rising edges of sigin per gate window and
// measures the period of the most recent input cycle in clk cycles.
module freq_meter #(
   parameter int unsigned CLK_HZ      = 20_000_000,
   parameter int unsigned GATE_CYCLES = 20_000_000,
   parameter int unsigned PER_W       = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sigin,
   output logic [30:0]      hz,
   output logic             hz_valid,
   output logic [PER_W-1:0] period,
   output logic             period_valid,
   output logic             no_signal
);

   localparam int unsigned GateW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam logic [GateW-1:0] GateLast = GateW'(GATE_CYCLES - 1);
   localparam logic [30:0] EdgeMax = '1;
   localparam logic [PER_W-1:0] PerMax = '1;
   localparam logic [PER_W-1:0] PerOne = PER_W'(1);

   if (CLK_HZ == 0 || GATE_CYCLES == 0 || PER_W < 2) begin : g_param_check
      $error("freq_meter: CLK_HZ and GATE_CYCLES must be non-zero and PER_W at least 2");
   end

   typedef enum logic [0:0] {
      StIdle,
      StMeasure
   } state_e;

   // Synchronizer and edge detector
   logic s1_q, s2_q, s3_q;
   logic rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
      end else begin
         s1_q <= sigin;
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   end

   assign rise = s2_q & ~s3_q;

   // Gate path
   logic [GateW-1:0] gate_cnt_q, gate_cnt_d;
   logic [30:0]      edge_cnt_q, edge_cnt_d;
   logic [30:0]      edge_sum;
   logic [30:0]      hz_q, hz_d;
   logic             hz_valid_q, hz_valid_d;
   logic             gate_end;

   assign gate_end = (gate_cnt_q == GateLast);

   always_comb begin
      gate_cnt_d = gate_cnt_q + GateW'(1);
      edge_cnt_d = edge_cnt_q;
      hz_d       = hz_q;
      hz_valid_d = 1'b0;
      // Saturating sum also feeds hz so an edge in the closing cycle is kept in its window
      edge_sum   = (rise && (edge_cnt_q != EdgeMax)) ? edge_cnt_q + 31'd1 : edge_cnt_q;
      if (gate_end) begin
         gate_cnt_d = '0;
         edge_cnt_d = '0;
         hz_d       = edge_sum;
         hz_valid_d = 1'b1;
      end else begin
         edge_cnt_d = edge_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gate_cnt_q <= '0;
         edge_cnt_q <= '0;
         hz_q       <= '0;
         hz_valid_q <= 1'b0;
      end else begin
         gate_cnt_q <= gate_cnt_d;
         edge_cnt_q <= edge_cnt_d;
         hz_q       <= hz_d;
         hz_valid_q <= hz_valid_d;
      end
   end

   // Period path
   state_e           state_q, state_d;
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [PER_W-1:0] period_q, period_d;
   logic             period_valid_q, period_valid_d;
   logic             no_signal_q, no_signal_d;

   always_comb begin
      state_d        = state_q;
      per_cnt_d      = per_cnt_q;
      period_d       = period_q;
      period_valid_d = 1'b0;
      no_signal_d    = no_signal_q;
      unique case (state_q)
         StIdle: begin
            per_cnt_d = '0;
            if (rise) begin
               state_d   = StMeasure;
               per_cnt_d = PerOne;
            end
         end
         StMeasure: begin
            // A rise on the timeout cycle still reports the full-scale period
            if (rise) begin
               period_d       = per_cnt_q;
               period_valid_d = 1'b1;
               no_signal_d    = 1'b0;
               per_cnt_d      = PerOne;
            end else if (per_cnt_q == PerMax) begin
               state_d     = StIdle;
               no_signal_d = 1'b1;
               per_cnt_d   = '0;
            end else begin
               per_cnt_d = per_cnt_q + PerOne;
            end
         end
         default: begin
            state_d   = StIdle;
            per_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= StIdle;
         per_cnt_q      <= '0;
         period_q       <= '0;
         period_valid_q <= 1'b0;
         no_signal_q    <= 1'b1;
      end else begin
         state_q        <= state_d;
         per_cnt_q      <= per_cnt_d;
         period_q       <= period_d;
         period_valid_q <= period_valid_d;
         no_signal_q    <= no_signal_d;
      end
   end

   assign hz           = hz_q;
   assign hz_valid     = hz_valid_q;
   assign period       = period_q;
   assign period_valid = period_valid_q;
   assign no_signal    = no_signal_q;

endmodule
